// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 control-unit front end: PC select codes,
// fetch FSM states and status-register bit positions.
package legv8_pkg;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BRANCH = 2'b10;
    localparam logic [1:0] PS_REG    = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Status register layout is {V,C,N,Z,Zr}
    localparam int STATUS_ZR = 0;
    localparam int STATUS_Z  = 1;
    localparam int STATUS_N  = 2;
    localparam int STATUS_C  = 3;
    localparam int STATUS_V  = 4;
    localparam int STATUS_W  = 5;

endpackage

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Combinational next-PC selection: hold, +4, PC-relative word branch, or
// register target with the low two bits forced to zero.
module pc_next_logic
    import legv8_pkg::*;
#(
    parameter int AW = 64
) (
    input  logic [1:0]    ps,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] constant,
    input  logic [AW-1:0] reg_in,
    output logic [AW-1:0] next_pc,
    output logic [AW-1:0] pc_plus4
);

    localparam logic [AW-1:0] FOUR     = AW'(3'd4);
    localparam logic [AW-1:0] LOW_MASK = ~AW'(2'b11);

    assign pc_plus4 = pc + FOUR;

    // Select the candidate PC; all additions wrap modulo 2^AW
    always_comb begin
        next_pc = pc;
        case (ps)
            PS_HOLD:   next_pc = pc;
            PS_INC:    next_pc = pc_plus4;
            PS_BRANCH: next_pc = pc + (constant << 2);
            PS_REG:    next_pc = reg_in & LOW_MASK;
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns PC, instruction and status registers, runs the
// instruction-memory handshake and stalls the control unit during a fetch.
module instruction_fetch_unit
    import legv8_pkg::*;
#(
    parameter int            AW       = 64,
    parameter logic [AW-1:0] PC_RESET = {AW{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          ps,
    input  logic                il,
    input  logic                sl,
    input  logic [AW-1:0]       constant,
    input  logic [AW-1:0]       reg_in,
    input  logic [STATUS_W-1:0] status_in,
    output logic                imem_req,
    output logic [AW-1:0]       imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_valid,
    output logic [31:0]         instruction,
    output logic [STATUS_W-1:0] status,
    output logic [AW-1:0]       pc,
    output logic [AW-1:0]       pc_plus4,
    output logic                stall
);

    fetch_state_e        state_q, state_d;
    logic                imem_req_q, imem_req_d;
    logic [AW-1:0]       imem_addr_q, imem_addr_d;
    logic [31:0]         instruction_q, instruction_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [AW-1:0]       next_pc_s;
    logic                stall_s;

    pc_next_logic #(.AW(AW)) u_pc_next (
        .ps       (ps),
        .pc       (pc_q),
        .constant (constant),
        .reg_in   (reg_in),
        .next_pc  (next_pc_s),
        .pc_plus4 (pc_plus4)
    );

    // Fetch FSM, stall generation and architectural register updates
    always_comb begin
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instruction_d = instruction_q;
        status_d      = status_q;
        pc_d          = pc_q;
        stall_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (il) begin
                    stall_s     = 1'b1;
                    state_d     = WAIT;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                end else begin
                    imem_req_d  = 1'b0;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    instruction_d = imem_rdata;
                    imem_req_d    = 1'b0;
                    state_d       = IDLE;
                end else begin
                    stall_s       = 1'b1;
                    imem_req_d    = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase

        // The completing fetch edge also applies the word's PC/status update
        if (!stall_s) begin
            pc_d = next_pc_s;
            if (sl) begin
                status_d = status_in;
            end else begin
                status_d = status_q;
            end
        end else begin
            pc_d     = pc_q;
            status_d = status_q;
        end
    end

    // State and register file; reset abandons any outstanding fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= {AW{1'b0}};
            instruction_q <= 32'h0;
            status_q      <= {STATUS_W{1'b0}};
            pc_q          <= PC_RESET;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instruction_q <= instruction_d;
            status_q      <= status_d;
            pc_q          <= pc_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instruction = instruction_q;
    assign status      = status_q;
    assign pc          = pc_q;
    assign stall       = stall_s;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by random control words and memory latencies against a behavioural model.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ps;
    logic        il, sl;
    logic [63:0] constant, reg_in;
    logic [4:0]  status_in;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [63:0] pc, pc_plus4;
    logic        stall;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.AW(64), .PC_RESET(64'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps          (ps),
        .il          (il),
        .sl          (sl),
        .constant    (constant),
        .reg_in      (reg_in),
        .status_in   (status_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instruction (instruction),
        .status      (status),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .stall       (stall)
    );

    // Reference model: architectural view of the fetch stage
    logic [63:0] m_pc, m_addr;
    logic [31:0] m_instr;
    logic [4:0]  m_status;
    bit          m_fetching;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cycles;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: check combinational outputs, advance model, check registers
    task automatic step();
        logic        exp_stall;
        logic [63:0] n_pc, n_addr;
        logic [31:0] n_instr;
        logic [4:0]  n_status;
        bit          n_fetching;
        #1;
        exp_stall = m_fetching ? !imem_valid : il;
        if (!reset) begin
            chk("stall", {63'd0, stall}, {63'd0, exp_stall});
            if (exp_stall) stall_cycles++;
        end
        chk("pc_plus4", pc_plus4, m_pc + 64'd4);

        n_pc = m_pc; n_addr = m_addr; n_instr = m_instr;
        n_status = m_status; n_fetching = m_fetching;
        if (reset) begin
            n_pc = 64'h0; n_addr = 64'h0; n_instr = 32'h0;
            n_status = 5'd0; n_fetching = 1'b0;
        end else begin
            if (!m_fetching && il) begin
                n_fetching = 1'b1;
                n_addr     = m_pc;
            end else if (m_fetching && imem_valid) begin
                n_fetching = 1'b0;
                n_instr    = imem_rdata;
            end
            if (!exp_stall) begin
                if (ps == 2'd1)      n_pc = m_pc + 64'd4;
                else if (ps == 2'd2) n_pc = m_pc + constant * 64'd4;
                else if (ps == 2'd3) n_pc = (reg_in / 64'd4) * 64'd4;
                if (sl) n_status = status_in;
            end
        end

        @(posedge clock);
        #1;
        m_pc = n_pc; m_addr = n_addr; m_instr = n_instr;
        m_status = n_status; m_fetching = n_fetching;
        chk("pc", pc, m_pc);
        chk("instruction", {32'd0, instruction}, {32'd0, m_instr});
        chk("status", {59'd0, status}, {59'd0, m_status});
        chk("imem_req", {63'd0, imem_req}, {63'd0, m_fetching});
        chk("imem_addr", imem_addr, m_addr);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; ps = 2'd0; il = 1'b0; sl = 1'b0;
        constant = 64'd0; reg_in = 64'd0; status_in = 5'd0;
        imem_rdata = 32'd0; imem_valid = 1'b0;
    endtask

    initial begin
        m_pc = 64'h0; m_addr = 64'h0; m_instr = 32'h0;
        m_status = 5'd0; m_fetching = 1'b0;
        idle_inputs();
        reset = 1'b1;
        step(); step();
        chk("rst_pc", pc, 64'h0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);

        // Single-cycle memory: fetch from 0, pc advances on completing edge
        reset = 1'b0; il = 1'b1; ps = 2'd1; stall_cycles = 0;
        step();
        chk("t1_addr", imem_addr, 64'h0);
        imem_valid = 1'b1; imem_rdata = 32'h8B020020;
        step();
        chk("t1_instr", {32'd0, instruction}, 64'h8B020020);
        chk("t1_pc", pc, 64'h4);
        chk("t1_stall_cycles", stall_cycles, 64'd1);
        idle_inputs(); step();

        // Three-cycle memory latency with junk control inputs while stalled
        il = 1'b1; ps = 2'd1; sl = 1'b1; status_in = 5'b11111; stall_cycles = 0;
        step();
        imem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            ps = 2'($urandom_range(0, 3)); constant = 64'($urandom);
            sl = 1'b1; status_in = 5'($urandom);
            step();
            chk("t2_hold_addr", imem_addr, 64'h4);
            chk("t2_hold_pc", pc, 64'h4);
        end
        ps = 2'd1; sl = 1'b0; imem_valid = 1'b1;
        step();
        chk("t2_stall_cycles", stall_cycles, 64'd4);
        chk("t2_pc", pc, 64'h8);
        idle_inputs();

        // Branch arithmetic and wrap-around
        ps = 2'd3; reg_in = 64'h100; step();
        ps = 2'd2; constant = 64'hFFFF_FFFF_FFFF_FFFC; step();
        chk("t3_branch", pc, 64'hF0);
        ps = 2'd3; reg_in = 64'hFFFF_FFFF_FFFF_FFFC; step();
        ps = 2'd1; step();
        chk("t3_wrap", pc, 64'h0);

        // Register target and status load, then the same word while stalled
        ps = 2'd3; reg_in = 64'h2003; sl = 1'b1; status_in = 5'b10101; step();
        chk("t4_pc", pc, 64'h2000);
        chk("t4_status", {59'd0, status}, {59'd0, 5'b10101});
        ps = 2'd1; status_in = 5'b00000; step();
        il = 1'b1; ps = 2'd3; reg_in = 64'h2003; status_in = 5'b10101; step();
        il = 1'b0; step();
        chk("t4_stall_pc", pc, 64'h2004);
        chk("t4_stall_status", {59'd0, status}, 64'd0);
        imem_valid = 1'b1; ps = 2'd0; sl = 1'b0; step();
        idle_inputs();

        // Reset during an outstanding fetch abandons it
        il = 1'b1; step();
        il = 1'b0; reset = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF; step();
        reset = 1'b0; step();
        chk("t5_req", {63'd0, imem_req}, 64'd0);
        chk("t5_pc", pc, 64'h0);
        chk("t5_instr", {32'd0, instruction}, 64'h0);
        idle_inputs();

        // Random control words and memory timing
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            il         = ($urandom_range(0, 2) == 0);
            ps         = 2'($urandom_range(0, 3));
            sl         = 1'($urandom);
            constant   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                                     : 64'($signed(32'($urandom_range(0, 64)) - 32'd32));
            reg_in     = {$urandom, $urandom};
            status_in  = 5'($urandom);
            imem_rdata = $urandom;
            imem_valid = m_fetching ? ($urandom_range(0, 2) == 0) : 1'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of the LEGv8 control unit.
- Owns the program counter (PC), the instruction register that feeds the control unit, and the 5-bit status register.
- Runs the handshake with instruction memory.
- Applies the PS, IL and SL fields of the control word together with the generated constant; back-pressures the control unit with stall while a fetch is outstanding.

Parameters:
- PC_RESET, 64'h0, PC value loaded on reset; bits [1:0] must be 0.
- AW, 64, address/data width of PC, constant and reg_in.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ps  input  2  PC select from control word
- il  input  1  instruction load request (IF control word)
- sl  input  1  status load
- constant  input  AW  sign-extended word offset from constant generator
- reg_in  input  AW  register-file A bus (BR/BLR/RET target)
- status_in  input  5  ALU flags {V,C,N,Z,Zr}
- imem_req  output  1  fetch request, registered
- imem_addr  output  AW  fetch address, registered
- imem_rdata  input  32  instruction word
- imem_valid  input  1  imem_rdata valid this cycle
- instruction  output  32  instruction register to control unit
- status  output  5  status register
- pc  output  AW  current PC
- pc_plus4  output  AW  pc+4 (BL link value), combinational
- stall  output  1  hold control-unit state register and all datapath writes

Behaviour:
- Reset, synchronous and dominant over everything:
  - pc=PC_RESET, instruction=32'h0, status=5'b0, imem_req=0, imem_addr=0, FSM=IDLE.
  - A fetch in flight is abandoned; an imem_valid arriving afterwards is ignored.
- FSM has two states, IDLE and WAIT.
  - IDLE, il=1: next edge imem_req<=1, imem_addr<=pc, go to WAIT.
  - IDLE, il=0: imem_req<=0.
  - WAIT, imem_valid=0: hold imem_req=1 and imem_addr.
  - WAIT, imem_valid=1: instruction<=imem_rdata, imem_req<=0, go to IDLE.
- stall = (IDLE & il) | (WAIT & ~imem_valid), combinational. Minimum fetch latency is 2 cycles: issue edge plus the first possible valid.
- imem_valid in IDLE is ignored.
- PC update happens only when stall=0, at the same edge as the instruction load for IF words:
  - ps=00: hold.
  - ps=01: pc+4.
  - ps=10: pc + (constant<<2), AW-bit wrap-around, no overflow flag.
  - ps=11: {reg_in[AW-1:2],2'b00}. Low bits are silently forced to zero.
- pc+4 wraps modulo 2^AW; all-ones-aligned pc goes to 0.
- Status: if sl & ~stall then status<=status_in; otherwise hold.
- When stall=1, the ps, sl and constant inputs are don't-care. No state other than the FSM and imem outputs changes.
- il=1 with ps=10 or 11 in the same word is legal: the fetch completes first, then the PC update is applied on the completing edge.

Decomposition:
- Shared package legv8_pkg, holding:
  - PS encodings: PS_HOLD=2'b00, PS_INC=2'b01, PS_BRANCH=2'b10, PS_REG=2'b11.
  - Fetch FSM encoding: IDLE=1'b0, WAIT=1'b1.
  - Status bit indices.
- One sub-module, pc_next_logic: combinational next-PC mux/adders producing next_pc and pc_plus4. Registers stay in the top.

Test Plan:
- Reset, then il=1, ps=01, imem_valid asserted 1 cycle after imem_req → imem_addr=0x0; instruction=imem_rdata (0x8B020020); pc=0x4 on the completing edge; stall high exactly 1 cycle.
- Memory delays valid 3 cycles → imem_req and imem_addr=0x4 held stable throughout; stall high 4 cycles; pc, status and instruction unchanged until the valid edge.
- pc=0x100, ps=10, constant=-4 (0xFFFF_FFFF_FFFF_FFFC), il=0 → pc=0xF0 next edge. pc=0xFFFF_FFFF_FFFF_FFFC, ps=01 → pc=0x0.
- ps=11, reg_in=0x2003 → pc=0x2000. sl=1, status_in=5'b10101 → status=5'b10101. Repeat with the same values during a stall → pc and status unchanged.
- Assert reset while in WAIT, then pulse imem_valid=1 with rdata 0xDEADBEEF → imem_req=0, pc=PC_RESET, instruction=0, FSM=IDLE, rdata not captured.
